// File: rtl/hazard_control_unit_pkg.sv
// Shared definitions for the hazard control unit: FSM state encoding,
// default drain length, counter width and the canonical NOP instruction.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } hazard_state_e;

  localparam int DEFAULT_DRAIN_CYCLES = 4;
  localparam int DEFAULT_CNT_W        = 16;

  // addi x0,x0,0 -- what IF/ID holds after a flush
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/hazard_control_unit_if.sv
// Bundle of pipeline-side hazard inputs and control outputs.
// The master side is the pipeline (drives hazard information, consumes
// enables); the slave side is the hazard control unit.
// Optional macro HAZARD_STATS_EN adds the statistics counter signals.
interface hazard_control_unit_if
  import hazard_pkg::*;
`ifdef HAZARD_STATS_EN
  #(parameter int CNT_W = DEFAULT_CNT_W)
`endif
  ;

  logic       i_ID_EX_mem_read;
  logic [4:0] i_ID_EX_rd;
  logic [4:0] i_IF_ID_rs1;
  logic [4:0] i_IF_ID_rs2;
  logic       i_branch_taken;
  logic       i_dbg_halt_req;
  logic       i_dbg_resume;

  logic       o_pc_write;
  logic       o_IF_ID_write;
  logic       o_IF_ID_flush;
  logic       o_ID_EX_bubble;
  logic       o_pipe_freeze;
  logic       o_dbg_halted;

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] o_stall_count;
  logic [CNT_W-1:0] o_flush_count;
`endif

  modport master (
    output i_ID_EX_mem_read, i_ID_EX_rd, i_IF_ID_rs1, i_IF_ID_rs2,
           i_branch_taken, i_dbg_halt_req, i_dbg_resume,
    input  o_pc_write, o_IF_ID_write, o_IF_ID_flush, o_ID_EX_bubble,
           o_pipe_freeze, o_dbg_halted
`ifdef HAZARD_STATS_EN
    , input o_stall_count, o_flush_count
`endif
  );

  modport slave (
    input  i_ID_EX_mem_read, i_ID_EX_rd, i_IF_ID_rs1, i_IF_ID_rs2,
           i_branch_taken, i_dbg_halt_req, i_dbg_resume,
    output o_pc_write, o_IF_ID_write, o_IF_ID_flush, o_ID_EX_bubble,
           o_pipe_freeze, o_dbg_halted
`ifdef HAZARD_STATS_EN
    , output o_stall_count, o_flush_count
`endif
  );

endinterface

// File: rtl/hazard_control_unit_load_use_detector.sv
// Load-use hazard detector: flags when the load in EX writes a register
// that the instruction in ID reads. Writes to x0 never create a hazard.
module load_use_detector (
  input  logic       i_mem_read,
  input  logic [4:0] i_rd,
  input  logic [4:0] i_rs1,
  input  logic [4:0] i_rs2,
  output logic       o_load_use
);

  // Pure compare; the dependent instruction can use MEM/WB forwarding
  // after one bubble, so nothing else is needed here.
  always_comb begin
    o_load_use = i_mem_read && (i_rd != 5'd0) &&
                 ((i_rd == i_rs1) || (i_rd == i_rs2));
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: load-use stall, taken-branch flush and a
// drain-then-freeze debug halt handshake.
// Optional macro HAZARD_STATS_EN adds saturating stall/flush counters.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES
`ifdef HAZARD_STATS_EN
  , parameter int CNT_W = DEFAULT_CNT_W
`endif
) (
  input logic                  i_clk,
  input logic                  i_reset,
  hazard_control_unit_if.slave hz
);

  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  hazard_state_e state_q, state_d;
  logic [CW-1:0] drainCnt_q, drainCnt_d;
  logic          halted_q;

  logic loadUse;
  logic pcWrite, ifIdWrite, ifIdFlush, idExBubble, pipeFreeze;

  load_use_detector u_lud (
    .i_mem_read (hz.i_ID_EX_mem_read),
    .i_rd       (hz.i_ID_EX_rd),
    .i_rs1      (hz.i_IF_ID_rs1),
    .i_rs2      (hz.i_IF_ID_rs2),
    .o_load_use (loadUse)
  );

  // State register, drain counter and the registered halted flag, which
  // rises in the same cycle the FSM enters HALTED.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= RUN;
      drainCnt_q <= '0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      drainCnt_q <= drainCnt_d;
      halted_q   <= (state_d == HALTED);
    end
  end

  // Next state: the drain counter starts at DRAIN_CYCLES-1 so the FSM
  // spends exactly DRAIN_CYCLES cycles in DRAIN; halt_req dropping during
  // the drain does not abort it, and resume only matters when HALTED.
  always_comb begin
    state_d    = state_q;
    drainCnt_d = drainCnt_q;
    case (state_q)
      RUN: begin
        if (hz.i_dbg_halt_req) begin
          state_d    = DRAIN;
          drainCnt_d = CW'(DRAIN_CYCLES - 1);
        end
      end
      DRAIN: begin
        if (drainCnt_q == '0) begin
          state_d = HALTED;
        end else begin
          drainCnt_d = drainCnt_q - CW'(1);
        end
      end
      HALTED: begin
        if (hz.i_dbg_resume) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d    = RUN;
        drainCnt_d = '0;
      end
    endcase
  end

  // Control outputs, combinational from state and inputs; a taken branch
  // outranks load-use, and reset forces a flushed, bubbled, stalled front end.
  always_comb begin
    pcWrite    = 1'b1;
    ifIdWrite  = 1'b1;
    ifIdFlush  = 1'b0;
    idExBubble = 1'b0;
    pipeFreeze = 1'b0;
    if (i_reset) begin
      pcWrite    = 1'b0;
      ifIdWrite  = 1'b0;
      ifIdFlush  = 1'b1;
      idExBubble = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (hz.i_branch_taken) begin
            ifIdFlush  = 1'b1;
            idExBubble = 1'b1;
          end else if (loadUse) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            idExBubble = 1'b1;
          end
        end
        DRAIN: begin
          pcWrite    = hz.i_branch_taken;
          ifIdWrite  = 1'b0;
          ifIdFlush  = hz.i_branch_taken;
          idExBubble = 1'b1;
        end
        HALTED: begin
          pcWrite    = 1'b0;
          ifIdWrite  = 1'b0;
          pipeFreeze = 1'b1;
        end
        default: begin
          pcWrite    = 1'b0;
          ifIdWrite  = 1'b0;
          ifIdFlush  = 1'b1;
          idExBubble = 1'b1;
        end
      endcase
    end
  end

  assign hz.o_pc_write     = pcWrite;
  assign hz.o_IF_ID_write  = ifIdWrite;
  assign hz.o_IF_ID_flush  = ifIdFlush;
  assign hz.o_ID_EX_bubble = idExBubble;
  assign hz.o_pipe_freeze  = pipeFreeze;
  assign hz.o_dbg_halted   = halted_q && !i_reset;

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stallCnt_q;
  logic [CNT_W-1:0] flushCnt_q;
  logic             stallEvent;
  logic             flushEvent;

  assign stallEvent = (state_q == RUN) && loadUse && !hz.i_branch_taken;
  assign flushEvent = ifIdFlush;

  // Saturating event counters, frozen while the pipeline is halted.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else if (state_q != HALTED) begin
      if (stallEvent && !(&stallCnt_q)) begin
        stallCnt_q <= stallCnt_q + CNT_W'(1);
      end
      if (flushEvent && !(&flushCnt_q)) begin
        flushCnt_q <= flushCnt_q + CNT_W'(1);
      end
    end
  end

  assign hz.o_stall_count = stallCnt_q;
  assign hz.o_flush_count = flushCnt_q;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: a vector table for the
// single-cycle hazard decisions plus hand-written halt/resume/reset
// sequences. Expected outputs go through a scoreboard queue.
module tb_hazard_control_unit;
  import hazard_pkg::*;

  // Expected output vector order: {pc_write, IF_ID_write, flush, bubble, freeze, halted}
  localparam logic [5:0] E_RUN   = 6'b110000;
  localparam logic [5:0] E_STALL = 6'b000100;
  localparam logic [5:0] E_BR    = 6'b111100;
  localparam logic [5:0] E_DRAIN = 6'b000100;
  localparam logic [5:0] E_DRBR  = 6'b101100;
  localparam logic [5:0] E_HALT  = 6'b000011;
  localparam logic [5:0] E_RST   = 6'b001100;

  typedef struct {
    logic       reset;
    logic       memRead;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       branch;
    logic       halt;
    logic       resume;
    logic [5:0] exp;
  } stim_t;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  logic [5:0] expQ[$];
  string      nameQ[$];

`ifdef HAZARD_STATS_EN
  hazard_control_unit_if #(.CNT_W(16)) hzIf ();
  hazard_control_unit #(.DRAIN_CYCLES(4), .CNT_W(16)) dut (
    .i_clk   (clock),
    .i_reset (reset),
    .hz      (hzIf)
  );
`else
  hazard_control_unit_if hzIf ();
  hazard_control_unit #(.DRAIN_CYCLES(4)) dut (
    .i_clk   (clock),
    .i_reset (reset),
    .hz      (hzIf)
  );
`endif

  // Free-running clock, 10 time units per period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard time limit so a broken DUT can never hang the run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic stim_t mk(input logic r, input logic mr, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic br, input logic hr, input logic rs,
                               input logic [5:0] e);
    stim_t s;
    s.reset = r;  s.memRead = mr; s.rd = rd; s.rs1 = rs1; s.rs2 = rs2;
    s.branch = br; s.halt = hr; s.resume = rs; s.exp = e;
    return s;
  endfunction

  task automatic applyStimulus(input stim_t s, input string nm);
    reset                 = s.reset;
    hzIf.i_ID_EX_mem_read = s.memRead;
    hzIf.i_ID_EX_rd       = s.rd;
    hzIf.i_IF_ID_rs1      = s.rs1;
    hzIf.i_IF_ID_rs2      = s.rs2;
    hzIf.i_branch_taken   = s.branch;
    hzIf.i_dbg_halt_req   = s.halt;
    hzIf.i_dbg_resume     = s.resume;
    expQ.push_back(s.exp);
    nameQ.push_back(nm);
  endtask

  task automatic checkOutput();
    logic [5:0] act;
    logic [5:0] e;
    string      nm;
    @(negedge clock);
    act = {hzIf.o_pc_write, hzIf.o_IF_ID_write, hzIf.o_IF_ID_flush,
           hzIf.o_ID_EX_bubble, hzIf.o_pipe_freeze, hzIf.o_dbg_halted};
    checks++;
    if (expQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_empty: actual=%b required=entry", act);
    end else begin
      e  = expQ.pop_front();
      nm = nameQ.pop_front();
      if (act !== e) begin
        errors++;
        $display("[TB] FAIL %s: actual=%b required=%b (pc,ifid,flush,bubble,freeze,halted)", nm, act, e);
      end
    end
  endtask

  task automatic step(input stim_t s, input string nm);
    applyStimulus(s, nm);
    checkOutput();
    @(posedge clock);
    #1;
  endtask

  task automatic checkVal(input string nm, input int act, input int e);
    checks++;
    if (act != e) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", nm, act, e);
    end
  endtask

  stim_t vecs[12];
  int    expStall;
  int    expFlush;

  // Main stimulus: reset, vector table, then multi-cycle corner cases.
  initial begin
    checks = 0;
    errors = 0;
    expStall = 0;
    expFlush = 0;
    reset = 1'b1;
    hzIf.i_ID_EX_mem_read = 1'b0;
    hzIf.i_ID_EX_rd       = 5'd0;
    hzIf.i_IF_ID_rs1      = 5'd0;
    hzIf.i_IF_ID_rs2      = 5'd0;
    hzIf.i_branch_taken   = 1'b0;
    hzIf.i_dbg_halt_req   = 1'b0;
    hzIf.i_dbg_resume     = 1'b0;

    vecs[0]  = mk(0, 0,  5,  5,  7, 0, 0, 0, E_RUN);
    vecs[1]  = mk(0, 1,  5,  5,  7, 0, 0, 0, E_STALL);
    vecs[2]  = mk(0, 0,  0,  5,  7, 0, 0, 0, E_RUN);
    vecs[3]  = mk(0, 1,  0,  0,  0, 0, 0, 0, E_RUN);
    vecs[4]  = mk(0, 1,  9,  3,  9, 0, 0, 0, E_STALL);
    vecs[5]  = mk(0, 1,  9,  3,  4, 0, 0, 0, E_RUN);
    vecs[6]  = mk(0, 1, 12, 12,  1, 1, 0, 0, E_BR);
    vecs[7]  = mk(0, 0,  0,  1,  2, 0, 0, 0, E_RUN);
    vecs[8]  = mk(0, 0,  0,  0,  0, 1, 0, 0, E_BR);
    vecs[9]  = mk(0, 1, 31,  0, 31, 0, 0, 0, E_STALL);
    vecs[10] = mk(0, 0, 31, 31, 31, 0, 0, 1, E_RUN);
    vecs[11] = mk(0, 1, 31, 31, 31, 0, 0, 0, E_STALL);

    @(posedge clock);
    #1;
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, E_RST), "reset_a");
    step(mk(1, 1, 5, 5, 0, 0, 1, 0, E_RST), "reset_b");
`ifdef HAZARD_STATS_EN
    checkVal("stall_cnt_reset", int'(hzIf.o_stall_count), 0);
    checkVal("flush_cnt_reset", int'(hzIf.o_flush_count), 0);
`endif

    foreach (vecs[i]) begin
      step(vecs[i], $sformatf("vec%0d", i));
      if (vecs[i].exp == E_STALL) expStall++;
      if (vecs[i].exp[3]) expFlush++;
    end
`ifdef HAZARD_STATS_EN
    checkVal("stall_cnt", int'(hzIf.o_stall_count), expStall);
    checkVal("flush_cnt", int'(hzIf.o_flush_count), expFlush);
`endif

    // Halt: request for one cycle, branch in 2nd drain cycle, stray resume.
    step(mk(0, 0, 0, 0, 0, 0, 1, 0, E_RUN),   "halt_req_run");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, E_DRAIN), "drain1");
    step(mk(0, 0, 0, 0, 0, 1, 0, 0, E_DRBR),  "drain2_branch");
    step(mk(0, 1, 3, 3, 0, 0, 0, 1, E_DRAIN), "drain3_resume_ignored");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, E_DRAIN), "drain4");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, E_HALT),  "halted1");
    step(mk(0, 1, 4, 4, 4, 0, 1, 0, E_HALT),  "halted_lu");
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, E_HALT),  "halted_resume");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, E_RUN),   "resumed_run");

    // Re-halt: halt request held high across the resume.
    step(mk(0, 0, 0, 0, 0, 0, 1, 0, E_RUN),   "rehalt_req");
    for (int k = 0; k < 4; k++) begin
      step(mk(0, 0, 0, 0, 0, 0, 1, 0, E_DRAIN), $sformatf("rehalt_drain%0d", k));
    end
    step(mk(0, 0, 0, 0, 0, 0, 1, 0, E_HALT),  "rehalt_halted");
    step(mk(0, 0, 0, 0, 0, 0, 1, 1, E_HALT),  "rehalt_resume");
    step(mk(0, 0, 0, 0, 0, 0, 1, 0, E_RUN),   "rehalt_run_once");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, E_DRAIN), "rehalt_drain_again");

    // Reset in the middle of DRAIN discards the pending halt.
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, E_RST),   "reset_in_drain");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, E_RUN),   "run_after_drain_reset");

    // Reach HALTED again, then reset there.
    step(mk(0, 0, 0, 0, 0, 0, 1, 0, E_RUN),   "halt2_req");
    for (int k = 0; k < 4; k++) begin
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, E_DRAIN), $sformatf("halt2_drain%0d", k));
    end
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, E_HALT),  "halt2_halted");
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, E_RST),   "reset_in_halted");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, E_RUN),   "run_after_halt_reset");
`ifdef HAZARD_STATS_EN
    checkVal("stall_cnt_after_reset", int'(hzIf.o_stall_count), 0);
    checkVal("flush_cnt_after_reset", int'(hzIf.o_flush_count), 0);
`endif
    checkVal("scoreboard_drained", expQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
